// File: rtl/gray_frame_ctrl_pkg.sv
// Shared types and constants for the RGB444-to-gray frame converter.
// Holds the FSM state encoding, RGB444 field positions and gray weight shifts.
package gray_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // RGB444 pixel layout {R[11:8], G[7:4], B[3:0]}
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // gray = R/4 + G/2 + G/8 + B/8, each term truncated before the sum
    localparam int R_SH    = 2;
    localparam int G_SH_HI = 1;
    localparam int G_SH_LO = 3;
    localparam int B_SH    = 3;

endpackage

// File: rtl/gray_frame_ctrl_if.sv
// Bus bundle between the frame controller and its ROM/RAM/control environment.
// The controller uses the master view; the environment (ROM, RAM, sequencer) the slave view.
interface gray_frame_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              hold;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_din;
    logic              ram_we;
    logic              busy;
    logic              done;

    modport master (
        input  start, hold, rom_data,
        output rom_addr, ram_addr, ram_din, ram_we, busy, done
    );

    modport slave (
        output start, hold, rom_data,
        input  rom_addr, ram_addr, ram_din, ram_we, busy, done
    );
endinterface

// File: rtl/gray_frame_ctrl_gray_pix.sv
// Combinational RGB444 to 4-bit gray conversion using shift-only weights.
// The largest possible result is 12, so the 4-bit sum never overflows.
module gray_pix
    import gray_frame_ctrl_pkg::*;
(
    input  logic [11:0] rgb,
    output logic [3:0]  gray
);
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;

    assign r    = rgb[R_MSB:R_LSB];
    assign g    = rgb[G_MSB:G_LSB];
    assign b    = rgb[B_MSB:B_LSB];
    assign gray = (r >> R_SH) + (g >> G_SH_HI) + (g >> G_SH_LO) + (b >> B_SH);
endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame controller: streams IMG_W*IMG_H RGB444 pixels from a 1-cycle-latency ROM,
// converts them to gray and writes them in order to a RAM, with lossless back-pressure.
module gray_frame_ctrl
    import gray_frame_ctrl_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_frame_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t            state;
    state_t            state_nxt;
    logic              busy_c;
    logic              done_c;

    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] wr_cnt;
    logic              rd_vld;
    logic              held_vld;
    logic [3:0]        held_pix;
    logic              out_vld;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [3:0]        ram_din_q;
    logic [3:0]        gray;

    logic              accept;
    logic              issue;
    logic              wr_fire;
    logic              out_free;

    gray_pix u_gray_pix (
        .rgb  (bus.rom_data),
        .gray (gray)
    );

    assign accept   = (state == IDLE) && bus.start;
    assign issue    = (state == RUN) && !bus.hold;
    assign wr_fire  = out_vld && !bus.hold;
    // The output register can take a new pixel when it is empty or being written now.
    assign out_free = !out_vld || !bus.hold;

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (issue && rom_addr_q == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (wr_fire && ram_addr_q == LAST_ADDR) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            wr_cnt     <= '0;
            rd_vld     <= 1'b0;
            held_vld   <= 1'b0;
            held_pix   <= '0;
            out_vld    <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            if (accept) begin
                rom_addr_q <= '0;
                wr_cnt     <= '0;
            end else if (issue && rom_addr_q != LAST_ADDR) begin
                rom_addr_q <= rom_addr_q + ADDR_W'(1);
            end

            // rom_data next cycle belongs to a real read only if one was issued now.
            rd_vld <= issue;

            // A parked pixel is always older than anything arriving from the ROM.
            if (out_free) begin
                if (held_vld) begin
                    out_vld    <= 1'b1;
                    ram_din_q  <= held_pix;
                    ram_addr_q <= wr_cnt;
                    wr_cnt     <= wr_cnt + ADDR_W'(1);
                    held_vld   <= 1'b0;
                end else if (rd_vld) begin
                    out_vld    <= 1'b1;
                    ram_din_q  <= gray;
                    ram_addr_q <= wr_cnt;
                    wr_cnt     <= wr_cnt + ADDR_W'(1);
                end else begin
                    out_vld    <= 1'b0;
                end
            end else if (rd_vld) begin
                held_vld <= 1'b1;
                held_pix <= gray;
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    // The strobe is masked by the live hold so no write lands in a back-pressured cycle.
    assign bus.ram_we   = wr_fire;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Self-checking bench for gray_frame_ctrl on a 4x4 frame: a transaction-level model
// checks every cycle, and directed scenarios pin latencies and data with literals.
module tb_gray_frame_ctrl;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 4;
    localparam int N      = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst_n;

    gray_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    gray_frame_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Source ROM with one cycle of read latency.
    logic [11:0] rom [N];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_ref(input logic [11:0] p);
        int r;
        int g;
        int b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        return r / 4 + g / 2 + g / 8 + b / 8;
    endfunction

    // Behavioural model state: frame phase, next expected read/write address, issue times.
    int         cyc = 0;
    bit         m_idle = 1'b1;
    bit         m_active = 1'b0;
    bit         m_done_due = 1'b0;
    int         m_next_rd = 0;
    int         m_next_wr = 0;
    int         iss [N];
    int         last_hold = -1;
    int         n_done = 0;
    int         first_wr_cyc = 0;
    int         last_wr_cyc = 0;
    int         done_cyc = 0;
    int         act_start_cyc = 0;
    int         frame_writes = 0;
    logic [3:0] wr_log [N];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_rom_addr", 32'(bus.rom_addr), 0);
            check("rst_ram_addr", 32'(bus.ram_addr), 0);
            check("rst_ram_din",  32'(bus.ram_din), 0);
            check("rst_ram_we",   32'(bus.ram_we), 0);
            check("rst_busy",     32'(bus.busy), 0);
            check("rst_done",     32'(bus.done), 0);
            m_idle     = 1'b1;
            m_active   = 1'b0;
            m_done_due = 1'b0;
        end else begin
            check("busy", 32'(bus.busy), 32'(m_active));
            check("done", 32'(bus.done), 32'(m_done_due));
            if (m_done_due) begin
                n_done++;
                done_cyc = cyc;
            end
            if (m_active) begin
                check("rom_addr", 32'(bus.rom_addr), (m_next_rd < N) ? m_next_rd : N - 1);
                if (bus.hold) begin
                    last_hold = cyc;
                    check("we_in_hold", 32'(bus.ram_we), 0);
                end
                if (bus.ram_we === 1'b1) begin
                    check("ram_addr", 32'(bus.ram_addr), m_next_wr);
                    if (m_next_wr < N) begin
                        check("ram_din", 32'(bus.ram_din), gray_ref(rom[m_next_wr]));
                        if (last_hold < iss[m_next_wr])
                            check("wr_latency", cyc - iss[m_next_wr], 2);
                    end
                    wr_log[bus.ram_addr] = bus.ram_din;
                    if (frame_writes == 0) first_wr_cyc = cyc;
                    frame_writes++;
                    if (int'(bus.ram_addr) == N - 1) last_wr_cyc = cyc;
                    m_next_wr++;
                end
                if (!bus.hold && m_next_rd < N) begin
                    iss[m_next_rd] = cyc;
                    m_next_rd++;
                end
            end else begin
                check("we_idle", 32'(bus.ram_we), 0);
            end

            if (m_active && bus.ram_we === 1'b1 && int'(bus.ram_addr) == N - 1) begin
                m_active   = 1'b0;
                m_done_due = 1'b1;
                check("frame_writes", frame_writes, N);
            end else if (m_done_due) begin
                m_done_due = 1'b0;
                m_idle     = 1'b1;
            end else if (m_idle && bus.start) begin
                m_idle        = 1'b0;
                m_active      = 1'b1;
                m_next_rd     = 0;
                m_next_wr     = 0;
                frame_writes  = 0;
                last_hold     = -1;
                act_start_cyc = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int tgt);
        for (int i = 0; i < 400 && n_done < tgt; i++) tick();
        check("done_reached", 32'(n_done >= tgt), 1);
    endtask

    int done_prev;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        for (int i = 0; i < N; i++) rom[i] = 12'hFFF;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Frame 1: all-white image, no back-pressure.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(1);
        check("s1_writes", frame_writes, 16);
        check("s1_din0", 32'(wr_log[0]), 12);
        check("s1_din15", 32'(wr_log[15]), 12);
        check("s1_first_lat", first_wr_cyc - iss[0], 2);
        check("s1_done_lat", done_cyc - last_wr_cyc, 1);

        // Frame 2: known colours up front, 3-cycle hold starting at rom_addr 5.
        rom[0] = 12'h000;
        rom[1] = 12'h840;
        rom[2] = 12'h00F;
        rom[3] = 12'h0F0;
        rom[4] = 12'hF00;
        for (int i = 5; i < N; i++) rom[i] = 12'(i * 419 + 77);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 100 && int'(bus.rom_addr) != 5; i++) tick();
        check("s2_reach5", 32'(bus.rom_addr), 5);
        bus.hold = 1'b1;
        tick();
        tick();
        tick();
        bus.hold = 1'b0;
        wait_done(2);
        check("s2_writes", frame_writes, 16);
        check("s2_din0", 32'(wr_log[0]), 0);
        check("s2_din1", 32'(wr_log[1]), 4);
        check("s2_din2", 32'(wr_log[2]), 1);
        check("s2_din3", 32'(wr_log[3]), 8);
        check("s2_din4", 32'(wr_log[4]), 3);

        // Frame 3: hold toggles every cycle.
        for (int i = 0; i < N; i++) rom[i] = 12'(i * 733 + 1234);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 200 && n_done < 3; i++) begin
            bus.hold = ~bus.hold;
            tick();
        end
        bus.hold = 1'b0;
        wait_done(3);
        repeat (3) tick();
        check("s3_one_done", n_done, 3);
        check("s3_writes", frame_writes, 16);

        // Frame 4: reset pulsed while address 7 is being written.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 100 && !(bus.ram_we === 1'b1 && int'(bus.ram_addr) == 7); i++) tick();
        check("s4_reach7", 32'(bus.ram_addr), 7);
        rst_n = 1'b0;
        #1;
        check("s4_rom_addr", 32'(bus.rom_addr), 0);
        check("s4_ram_addr", 32'(bus.ram_addr), 0);
        check("s4_ram_din", 32'(bus.ram_din), 0);
        check("s4_ram_we", 32'(bus.ram_we), 0);
        check("s4_busy", 32'(bus.busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("s4_idle_busy", 32'(bus.busy), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("s4_restart_addr", 32'(bus.rom_addr), 0);
        check("s4_restart_busy", 32'(bus.busy), 1);
        wait_done(4);
        check("s4_writes", frame_writes, 16);

        // Frames 5 and 6: start held high, frames run back to back.
        bus.start = 1'b1;
        wait_done(5);
        done_prev = done_cyc;
        wait_done(6);
        bus.start = 1'b0;
        check("s5_restart_gap", act_start_cyc - done_prev, 2);
        check("s5_writes", frame_writes, 16);
        repeat (4) tick();
        check("s5_stopped", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
